// File: rtl/conv_layer_sched_if.sv
// Signal bundle between the conv layer sequencer and its surroundings:
// host control, weight RAM, image RAM and conv engine ports.
interface conv_layer_sched_if #(
  parameter int WADDR_W = 12,
  parameter int IADDR_W = 18
);
  logic                      start;
  logic        [8:0]         image_size;
  logic        [7:0]         num_kernels;
  logic                      busy;
  logic                      done;
  logic                      err;
  logic        [7:0]         kernel_idx;
  logic                      wt_rd_en;
  logic        [WADDR_W-1:0] wt_rd_addr;
  logic        [15:0]        wt_rd_data;
  logic                      img_rd_en;
  logic        [IADDR_W-1:0] img_rd_addr;
  logic        [15:0]        img_rd_data;
  logic                      eng_weight_valid;
  logic signed [15:0]        eng_weight;
  logic                      eng_data_valid;
  logic signed [15:0]        eng_data;
  logic                      eng_map_valid;

  modport master (
    input  start, image_size, num_kernels, wt_rd_data, img_rd_data, eng_map_valid,
    output busy, done, err, kernel_idx, wt_rd_en, wt_rd_addr, img_rd_en, img_rd_addr,
           eng_weight_valid, eng_weight, eng_data_valid, eng_data
  );

  modport slave (
    output start, image_size, num_kernels, wt_rd_data, img_rd_data, eng_map_valid,
    input  busy, done, err, kernel_idx, wt_rd_en, wt_rd_addr, img_rd_en, img_rd_addr,
           eng_weight_valid, eng_weight, eng_data_valid, eng_data
  );
endinterface

// File: rtl/conv_layer_sched.sv
// Layer sequencer for the single-kernel 3x3 conv engine: per kernel it loads
// 9 weights + bias, streams the N x N image, then counts (N-2)^2 results.
module conv_layer_sched #(
  parameter int GAP_CYCLES = 4,
  parameter int TIMEOUT    = 1024,
  parameter int WADDR_W    = 12,
  parameter int IADDR_W    = 18
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  conv_layer_sched_if.master  bus
);

  typedef enum logic [2:0] {IDLE, LOAD_W, GAP, STREAM, DRAIN, NEXT, FIN} state_t;

  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int IW = $clog2(TIMEOUT);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES);
  localparam logic [GW-1:0] NEXT_LAST = GW'(GAP_CYCLES - 1);
  // FIN and the registered done add two cycles, so abort early enough that
  // done lands exactly TIMEOUT cycles after the last result pulse.
  localparam logic [IW-1:0] ABORT_AT  = IW'(TIMEOUT - 3);

  state_t               state_q, state_d;
  logic [7:0]           k_q, kernel_idx_q;
  logic [17:0]          target_q, npix_q, pix_q, res_q, res_next;
  logic [WADDR_W-1:0]   wt_base_q;
  logic [3:0]           wcnt_q;
  logic [GW-1:0]        gcnt_q;
  logic [IW-1:0]        idle_q;
  logic                 busy_q, done_q, err_q, wv_q, dv_q;
  logic                 wt_en, img_en, set_err, in_res, accept, last_kernel;
  logic [8:0]           n_m2;

  assign n_m2        = bus.image_size - 9'd2;
  assign accept      = (state_q == IDLE) && bus.start;
  assign in_res      = (state_q == STREAM) || (state_q == DRAIN);
  assign res_next    = res_q + 18'(in_res && bus.eng_map_valid);
  assign last_kernel = (kernel_idx_q == k_q - 8'd1);

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    wt_en   = 1'b0;
    img_en  = 1'b0;
    set_err = bus.eng_map_valid && !in_res;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.num_kernels == 8'd0 || bus.image_size < 9'd3) state_d = FIN;
          else                                                  state_d = LOAD_W;
        end
      end
      LOAD_W: begin
        wt_en = 1'b1;
        if (wcnt_q == 4'd9) state_d = GAP;
      end
      GAP: begin
        if (gcnt_q == GAP_LAST) state_d = STREAM;
      end
      STREAM: begin
        img_en = 1'b1;
        if (bus.eng_map_valid && res_q >= target_q) set_err = 1'b1;
        if (pix_q == npix_q - 18'd1) state_d = DRAIN;
      end
      DRAIN: begin
        if (res_next == target_q) begin
          state_d = NEXT;
        end else if (!bus.eng_map_valid && idle_q == ABORT_AT) begin
          set_err = 1'b1;
          state_d = FIN;
        end
      end
      NEXT: begin
        if (gcnt_q == NEXT_LAST) state_d = last_kernel ? FIN : LOAD_W;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments and an asynchronous
  // active-low reset, so every register clears the instant sys_rst_n drops.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= IDLE;
      k_q          <= '0;
      kernel_idx_q <= '0;
      target_q     <= '0;
      npix_q       <= '0;
      pix_q        <= '0;
      res_q        <= '0;
      wt_base_q    <= '0;
      wcnt_q       <= '0;
      gcnt_q       <= '0;
      idle_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      wv_q         <= 1'b0;
      dv_q         <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == FIN);
      wv_q    <= wt_en;
      dv_q    <= img_en;
      wcnt_q  <= (wt_en && state_d == LOAD_W) ? wcnt_q + 4'd1 : 4'd0;
      pix_q   <= (img_en && state_d == STREAM) ? pix_q + 18'd1 : 18'd0;
      idle_q  <= (state_q == DRAIN && !bus.eng_map_valid) ? idle_q + IW'(1) : '0;

      if (state_d != state_q)                      gcnt_q <= '0;
      else if (state_q == GAP || state_q == NEXT)  gcnt_q <= gcnt_q + GW'(1);

      // Result count restarts for each kernel as its weight burst begins.
      if (state_d == LOAD_W && state_q != LOAD_W) res_q <= '0;
      else                                        res_q <= res_next;

      if (accept)                busy_q <= 1'b1;
      else if (state_q == FIN)   busy_q <= 1'b0;

      if (accept)       err_q <= (bus.num_kernels != 8'd0) && (bus.image_size < 9'd3);
      else if (set_err) err_q <= 1'b1;

      if (accept) begin
        k_q          <= bus.num_kernels;
        kernel_idx_q <= '0;
        wt_base_q    <= '0;
        target_q     <= 18'(n_m2) * 18'(n_m2);
        npix_q       <= 18'(bus.image_size) * 18'(bus.image_size);
      end else if (state_q == NEXT && state_d == LOAD_W) begin
        kernel_idx_q <= kernel_idx_q + 8'd1;
        wt_base_q    <= wt_base_q + WADDR_W'(10);
      end
    end
  end

  assign bus.busy             = busy_q;
  assign bus.done             = done_q;
  assign bus.err              = err_q;
  assign bus.kernel_idx       = kernel_idx_q;
  assign bus.wt_rd_en         = wt_en;
  assign bus.wt_rd_addr       = wt_en ? wt_base_q + WADDR_W'(wcnt_q) : '0;
  assign bus.img_rd_en        = img_en;
  assign bus.img_rd_addr      = img_en ? IADDR_W'(pix_q) : '0;
  assign bus.eng_weight_valid = wv_q;
  assign bus.eng_weight       = wv_q ? signed'(bus.wt_rd_data) : '0;
  assign bus.eng_data_valid   = dv_q;
  assign bus.eng_data         = dv_q ? signed'(bus.img_rd_data) : '0;

endmodule

// File: tb/tb_conv_layer_sched.sv
// Bench for conv_layer_sched: RAM and engine models, a transaction monitor and
// expected sequences built from the layer rules with plain arithmetic.
module tb_conv_layer_sched;

  localparam int GAP = 4;
  localparam int TMO = 1024;

  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  int   cyc = 0;
  int   n_pass = 0, n_total = 0;

  conv_layer_sched_if #(.WADDR_W(12), .IADDR_W(18)) bus ();

  conv_layer_sched #(.GAP_CYCLES(GAP), .TIMEOUT(TMO), .WADDR_W(12), .IADDR_W(18)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc = cyc + 1;

  function automatic logic [15:0] wmem(input int a);
    return 16'(a * 37 + 5) ^ 16'h5a00;
  endfunction
  function automatic logic [15:0] imem(input int a);
    return 16'(a * 13 + 7);
  endfunction

  // RAM models: data one cycle after the strobe.
  always @(posedge sys_clk) begin
    bus.wt_rd_data  <= bus.wt_rd_en  ? wmem(int'(bus.wt_rd_addr))  : 16'hdead;
    bus.img_rd_data <= bus.img_rd_en ? imem(int'(bus.img_rd_addr)) : 16'hbeef;
  end

  // Engine model: one result per window whose bottom-right pixel is at
  // row>=2, col>=2, delivered e_lat cycles later, capped at e_limit.
  int       cur_n = 3, e_lat = 1, e_limit = 0, e_pix = 0, e_emit = 0;
  bit       spur_arm = 1'b0, prev_wv = 1'b0;
  bit [15:0] dl = '0;
  always @(posedge sys_clk) begin
    bit hit, spur;
    hit  = 1'b0;
    spur = spur_arm && prev_wv && !bus.eng_weight_valid;
    if (bus.eng_weight_valid) begin
      e_pix = 0; e_emit = 0;
    end else if (bus.eng_data_valid) begin
      if (e_pix / cur_n >= 2 && e_pix % cur_n >= 2 && e_emit < e_limit) begin
        hit = 1'b1; e_emit++;
      end
      e_pix++;
    end
    dl = {dl[14:0], hit};
    bus.eng_map_valid <= dl[e_lat-1] || spur;
    if (spur) spur_arm = 1'b0;
    prev_wv = bus.eng_weight_valid;
  end

  // Monitor
  int wa_q[$], wa_c[$], wd_q[$], wv_c[$], ia_q[$], ia_c[$], id_q[$], dv_c[$];
  int done_n = 0, done_cyc = 0, last_map = 0, start_cyc = 0;
  always @(negedge sys_clk) begin
    if (bus.wt_rd_en)  begin wa_q.push_back(int'(bus.wt_rd_addr));  wa_c.push_back(cyc); end
    if (bus.eng_weight_valid) begin wd_q.push_back(int'(bus.eng_weight)); wv_c.push_back(cyc); end
    if (bus.img_rd_en) begin ia_q.push_back(int'(bus.img_rd_addr)); ia_c.push_back(cyc); end
    if (bus.eng_data_valid) begin id_q.push_back(int'(bus.eng_data)); dv_c.push_back(cyc); end
    if (bus.done) begin done_n++; done_cyc = cyc; end
    if (bus.eng_map_valid) last_map = cyc;
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic clear_mon();
    wa_q.delete(); wa_c.delete(); wd_q.delete(); wv_c.delete();
    ia_q.delete(); ia_c.delete(); id_q.delete(); dv_c.delete();
    done_n = 0;
  endtask

  task automatic launch(input int n, k, lat, input bit drop, spur);
    clear_mon();
    cur_n = n; e_lat = lat; spur_arm = spur;
    e_limit = drop ? (n - 2) * (n - 2) - 1 : 1 << 30;
    @(negedge sys_clk);
    bus.image_size = 9'(n); bus.num_kernels = 8'(k); bus.start = 1'b1;
    start_cyc = cyc;
    @(negedge sys_clk);
    bus.start = 1'b0;
  endtask

  task automatic verify(input string tag, input int n, k, input bit drop, exp_err);
    int nk, np, bad;
    nk = (k == 0 || n < 3) ? 0 : (drop ? 1 : k);
    np = n * n;
    check({tag, ".done_cnt"}, done_n, 1);
    check({tag, ".err"}, bus.err, exp_err);
    check({tag, ".busy_low"}, bus.busy, 0);
    check({tag, ".kernel_idx"}, bus.kernel_idx, nk > 0 ? nk - 1 : 0);
    check({tag, ".wt_cnt"}, wa_q.size(), 10 * nk);
    check({tag, ".img_cnt"}, ia_q.size(), nk * np);
    bad = 0;
    foreach (wa_q[i]) begin
      if (wa_q[i] != i) bad++;
      if (wa_c[i] != wa_c[i - i % 10] + i % 10) bad++;
      if (i >= wd_q.size()) bad++;
      else if (wd_q[i] != int'(signed'(wmem(i))) || wv_c[i] != wa_c[i] + 1) bad++;
    end
    check({tag, ".wt_seq"}, bad, 0);
    bad = 0;
    foreach (ia_q[i]) begin
      if (ia_q[i] != i % np) bad++;
      if (ia_c[i] != ia_c[i - i % np] + i % np) bad++;
      if (i >= id_q.size()) bad++;
      else if (id_q[i] != int'(signed'(imem(i % np))) || dv_c[i] != ia_c[i] + 1) bad++;
    end
    check({tag, ".img_seq"}, bad, 0);
    bad = 0;
    for (int kk = 0; kk < nk; kk++)
      if (kk * np >= ia_c.size() || kk * 10 + 9 >= wa_c.size()) bad++;
      else if (ia_c[kk * np] - wa_c[kk * 10 + 9] != GAP + 2) bad++;
    check({tag, ".gap"}, bad, 0);
    if (nk == 0)   check({tag, ".done_lat"}, done_cyc - start_cyc, 2);
    else if (drop) check({tag, ".timeout_lat"}, done_cyc - last_map, TMO);
    else           check({tag, ".done_lat"}, done_cyc - last_map, GAP + 2);
  endtask

  task automatic run_case(input string tag, input int n, k, lat,
                          input bit drop, spur, restart, exp_err);
    bit rs = 1'b0;
    bit got = 1'b0;
    launch(n, k, lat, drop, spur);
    check({tag, ".busy_high"}, bus.busy, 1);
    for (int t = 0; t < 20000; t++) begin
      if (bus.done) begin got = 1'b1; break; end
      if (restart && !rs && bus.img_rd_en && bus.img_rd_addr == 18'd5) begin
        bus.start = 1'b1; bus.image_size = 9'd3; bus.num_kernels = 8'd0;
        @(negedge sys_clk);
        bus.start = 1'b0; bus.image_size = 9'(n); bus.num_kernels = 8'(k);
        rs = 1'b1;
      end else begin
        @(negedge sys_clk);
      end
    end
    if (!got) check({tag, ".done_seen"}, 0, 1);
    repeat (lat + 4) @(negedge sys_clk);
    verify(tag, n, k, drop, exp_err);
  endtask

  typedef struct {
    int n; int k; int lat; bit drop; bit spur; bit restart; bit exp_err;
  } vec_t;

  initial begin
    vec_t vecs[8];
    bit   got;
    vecs = '{
      '{5, 1, 3, 1'b0, 1'b0, 1'b0, 1'b0},   // basic single kernel
      '{4, 3, 2, 1'b0, 1'b0, 1'b0, 1'b0},   // three kernels
      '{5, 0, 2, 1'b0, 1'b0, 1'b0, 1'b0},   // no kernels
      '{2, 1, 2, 1'b0, 1'b0, 1'b0, 1'b1},   // image too small
      '{5, 3, 4, 1'b1, 1'b0, 1'b0, 1'b1},   // one result missing -> timeout
      '{4, 2, 3, 1'b0, 1'b1, 1'b0, 1'b1},   // spurious result in GAP
      '{3, 1, 1, 1'b0, 1'b0, 1'b0, 1'b0},   // smallest image, one result
      '{5, 2, 3, 1'b0, 1'b0, 1'b1, 1'b0}    // start re-pulsed mid-stream
    };
    bus.start = 1'b0; bus.image_size = '0; bus.num_kernels = '0;

    repeat (3) @(negedge sys_clk);
    check("reset.outputs", int'(|{bus.busy, bus.done, bus.err, bus.kernel_idx, bus.wt_rd_en,
          bus.wt_rd_addr, bus.img_rd_en, bus.img_rd_addr, bus.eng_weight_valid,
          bus.eng_weight, bus.eng_data_valid, bus.eng_data}), 0);
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);

    foreach (vecs[i])
      run_case($sformatf("vec%0d", i), vecs[i].n, vecs[i].k, vecs[i].lat,
               vecs[i].drop, vecs[i].spur, vecs[i].restart, vecs[i].exp_err);

    // Reset in the middle of STREAM: everything drops at once, no done.
    launch(6, 2, 2, 1'b0, 1'b0);
    got = 1'b0;
    for (int t = 0; t < 2000; t++) begin
      if (bus.img_rd_en && bus.img_rd_addr == 18'd10) begin got = 1'b1; break; end
      @(negedge sys_clk);
    end
    check("rst_mid.reached_stream", got, 1);
    #2 sys_rst_n = 1'b0;
    #1 check("rst_mid.outputs", int'(|{bus.busy, bus.done, bus.err, bus.kernel_idx, bus.wt_rd_en,
          bus.wt_rd_addr, bus.img_rd_en, bus.img_rd_addr, bus.eng_weight_valid,
          bus.eng_weight, bus.eng_data_valid, bus.eng_data}), 0);
    repeat (20) @(negedge sys_clk);
    check("rst_mid.no_done", done_n, 0);
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);
    run_case("after_rst", 4, 1, 2, 1'b0, 1'b0, 1'b0, 1'b0);

    // Randomised layers against the same rule-based expectations.
    for (int r = 0; r < 4; r++)
      run_case($sformatf("rand%0d", r), 3 + int'($urandom_range(0, 5)),
               int'($urandom_range(1, 3)), int'($urandom_range(1, 6)),
               1'b0, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/conv_layer_sched.md
Name: conv_layer_sched

Overview:
- Layer-level sequencer for the single-kernel 3x3 conv engine (weight port, pixel port, map output valid).
- Per output channel k = 0..num_kernels-1: fetches 10 words (9 weights row-major, then bias) from weight RAM and streams them to the engine.
- Then streams the full N x N input image from image RAM and counts (N-2)^2 engine results.
- Advances to the next kernel once all results are counted. Sits between the host/config register file and the conv engine.

Parameters:
- GAP_CYCLES, 4, idle cycles inserted after a weight burst and after each kernel completes (engine state settle); min 2.
- TIMEOUT, 1024, max cycles without an eng_map_valid while results are outstanding in DRAIN before abort.
- WADDR_W, 12, weight RAM address width.
- IADDR_W, 18, image RAM address width (covers 511x511).

Ports:
- sys_clk  in  1  clock.
- sys_rst_n  in  1  reset.
- start  in  1  single-cycle pulse; begin a layer (ignored unless IDLE).
- image_size  in  9  N, input image side; latched at start.
- num_kernels  in  8  number of kernels; latched at start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at layer end (normal or abort).
- err  out  1  sticky error flag; cleared on next accepted start.
- kernel_idx  out  8  index of the kernel in progress.
- wt_rd_en  out  1  weight RAM read strobe.
- wt_rd_addr  out  WADDR_W  weight RAM address.
- wt_rd_data  in  16  weight RAM data; valid 1 cycle after wt_rd_en.
- img_rd_en  out  1  image RAM read strobe.
- img_rd_addr  out  IADDR_W  image RAM address.
- img_rd_data  in  16  image RAM data; valid 1 cycle after img_rd_en.
- eng_weight_valid  out  1  to engine pi_weight_valid.
- eng_weight  out  16 signed  to engine pi_weight.
- eng_data_valid  out  1  to engine pi_data_valid.
- eng_data  out  16 signed  to engine pi_data.
- eng_map_valid  in  1  engine map_out_valid; one pulse per result.

Behaviour:
- Reset: sys_rst_n is asynchronous, active-low; clock is sys_clk. On reset all outputs are 0, state is IDLE and all counters are 0.
- Reset mid-operation aborts immediately. No done pulse. RAM strobes and engine valids drop in the reset cycle.
- States: IDLE, LOAD_W, GAP, STREAM, DRAIN, NEXT, FIN.
- IDLE:
  - start=1 latches N and K, clears err, sets busy and kernel_idx=0.
  - If K==0: go to FIN, err stays 0.
  - If N<3: go to FIN with err=1.
  - Otherwise go to LOAD_W.
  - start while not IDLE is ignored.
- LOAD_W:
  - wt_rd_en high for exactly 10 consecutive cycles, wt_rd_addr = kernel_idx*10 + 0..9.
  - eng_weight_valid = wt_rd_en delayed 1 cycle; eng_weight = wt_rd_data. This yields exactly 10 contiguous valids.
  - After the 10th strobe, go to GAP.
- GAP:
  - Counts GAP_CYCLES cycles starting the cycle after the last eng_weight_valid.
  - No strobes or valids are asserted during GAP.
  - Then go to STREAM.
- STREAM:
  - img_rd_en high for exactly N*N consecutive cycles, img_rd_addr 0..N*N-1 row-major.
  - eng_data_valid = img_rd_en delayed 1 cycle; eng_data = img_rd_data.
  - Then go to DRAIN.
- Result counter:
  - Cleared on entry to LOAD_W.
  - Increments on every eng_map_valid in STREAM or DRAIN.
  - Target is (N-2)^2, computed at start as an 18-bit unsigned value.
- DRAIN:
  - When count==target, go to NEXT. This is also checked on the cycle the final pulse arrives.
  - Idle counter resets on each eng_map_valid. If it reaches TIMEOUT: err=1, go to FIN (abort the remaining kernels).
- Extra results:
  - eng_map_valid outside STREAM/DRAIN sets err=1; it is otherwise ignored, no abort.
  - A count exceeding target in STREAM also sets err.
- NEXT:
  - GAP_CYCLES idle cycles.
  - If kernel_idx==K-1, go to FIN; else kernel_idx+1 and go to LOAD_W.
- FIN: done=1 for one cycle, busy=0 in that same cycle, then go to IDLE. kernel_idx holds its last value.
- Arithmetic: all address and counter arithmetic is unsigned. kernel_idx*10 fits in WADDR_W, max 2540+9.

Test Plan:
- N=5, K=1, engine model emits 9 results → 10 weight valids (addr 0..9, data passthrough), 4-cycle gap, 25 data valids (addr 0..24), done exactly once, err=0.
- N=4, K=3 → weight addresses 0-9, 10-19, 20-29; 16 data valids per kernel; kernel_idx 0,1,2; 4 results per kernel; a single done at the end.
- start with K=0 → done pulses 2 cycles after start, no RAM strobes, err=0. start with N=2, K=1 → done, err=1, no strobes.
- N=5, engine returns only 8 results → err=1 and done exactly TIMEOUT cycles after the 8th pulse; remaining kernels skipped.
- start re-pulsed mid-STREAM → ignored, addresses continue unbroken. Reset asserted mid-STREAM → all outputs 0 in the same cycle, no done. A fresh start afterwards runs cleanly from address 0.
- Spurious eng_map_valid during GAP → err=1, sequence still completes with done.
